// File: rtl/hazard_control_if.sv
// rtl/hazard_control_if.sv - pipeline-side hazard inputs, stage enables and perf counters
interface hazard_control_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IFID_RS1;
    logic [4:0]       IFID_RS2;
    logic             IFID_USE_RS1;
    logic             IFID_USE_RS2;
    logic             IFID_BRANCH;
    logic [4:0]       IDEX_RD;
    logic             IDEX_RegWrite;
    logic             IDEX_MemRead;
    logic [4:0]       EXMEM_RD;
    logic             EXMEM_MemRead;
    logic             BRANCH_TAKEN;
    logic             ICACHE_STALL;
    logic             DCACHE_STALL;
    logic             PERF_CLR;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Write;
    logic             EXMEM_Write;
    logic             MEMWB_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic [CNT_W-1:0] CNT_DSTALL;
    logic [CNT_W-1:0] CNT_FREEZE_CYC;
    logic [CNT_W-1:0] CNT_FREEZE_EVT;
    logic [CNT_W-1:0] CNT_FLUSH;
    logic             HANG;

    modport master (
        output IFID_RS1, IFID_RS2, IFID_USE_RS1, IFID_USE_RS2, IFID_BRANCH,
               IDEX_RD, IDEX_RegWrite, IDEX_MemRead, EXMEM_RD, EXMEM_MemRead,
               BRANCH_TAKEN, ICACHE_STALL, DCACHE_STALL, PERF_CLR,
        input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
               IDEX_Bubble, IFID_Flush, CNT_DSTALL, CNT_FREEZE_CYC,
               CNT_FREEZE_EVT, CNT_FLUSH, HANG
    );

    modport slave (
        input  IFID_RS1, IFID_RS2, IFID_USE_RS1, IFID_USE_RS2, IFID_BRANCH,
               IDEX_RD, IDEX_RegWrite, IDEX_MemRead, EXMEM_RD, EXMEM_MemRead,
               BRANCH_TAKEN, ICACHE_STALL, DCACHE_STALL, PERF_CLR,
        output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
               IDEX_Bubble, IFID_Flush, CNT_DSTALL, CNT_FREEZE_CYC,
               CNT_FREEZE_EVT, CNT_FLUSH, HANG
    );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use/branch stall, cache freeze, flush control with perf counters and watchdog
module hazard_control_unit #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input logic             clk,
    input logic             rst_n,
    hazard_control_if.slave hif
);
    localparam int SW = $clog2(WDOG_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX  = SW'(WDOG_LIMIT);
    localparam logic [SW-1:0] STREAK_LAST = SW'(WDOG_LIMIT - 1);

    typedef enum logic {RUN, FRZ} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_dstall;
    logic [CNT_W-1:0] cnt_freeze_cyc;
    logic [CNT_W-1:0] cnt_freeze_evt;
    logic [CNT_W-1:0] cnt_flush;
    logic [SW-1:0]    streak;
    logic             hang;

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic dstall;
    logic freeze_req;

    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic use1,
                                       input logic use2);
        return (rd != 5'd0) && ((use1 && rd == rs1) || (use2 && rd == rs2));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ID-stage branch compare only sees EXMEM/MEMWB forwarding, so an EX producer must stall it.
    always_comb begin
        load_use   = hif.IDEX_MemRead &&
                     src_match(hif.IDEX_RD, hif.IFID_RS1, hif.IFID_RS2, hif.IFID_USE_RS1, hif.IFID_USE_RS2);
        br_ex      = hif.IFID_BRANCH && hif.IDEX_RegWrite &&
                     src_match(hif.IDEX_RD, hif.IFID_RS1, hif.IFID_RS2, hif.IFID_USE_RS1, hif.IFID_USE_RS2);
        br_mem     = hif.IFID_BRANCH && hif.EXMEM_MemRead &&
                     src_match(hif.EXMEM_RD, hif.IFID_RS1, hif.IFID_RS2, hif.IFID_USE_RS1, hif.IFID_USE_RS2);
        dstall     = load_use || br_ex || br_mem;
        freeze_req = hif.ICACHE_STALL || hif.DCACHE_STALL;
    end

    always_comb begin
        hif.PC_Write    = 1'b1;
        hif.IFID_Write  = 1'b1;
        hif.IDEX_Write  = 1'b1;
        hif.EXMEM_Write = 1'b1;
        hif.MEMWB_Write = 1'b1;
        hif.IDEX_Bubble = 1'b0;
        hif.IFID_Flush  = 1'b0;
        if (freeze_req) begin
            hif.PC_Write    = 1'b0;
            hif.IFID_Write  = 1'b0;
            hif.IDEX_Write  = 1'b0;
            hif.EXMEM_Write = 1'b0;
            hif.MEMWB_Write = 1'b0;
        end else if (dstall) begin
            // A taken branch with stale operands is not trusted; it re-resolves after the stall.
            hif.PC_Write    = 1'b0;
            hif.IFID_Write  = 1'b0;
            hif.IDEX_Bubble = 1'b1;
        end else if (hif.BRANCH_TAKEN) begin
            hif.IFID_Flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            cnt_dstall     <= '0;
            cnt_freeze_cyc <= '0;
            cnt_freeze_evt <= '0;
            cnt_flush      <= '0;
            streak         <= '0;
            hang           <= 1'b0;
        end else begin
            case (state)
                RUN: if (freeze_req) state <= FRZ;
                FRZ: if (!freeze_req) state <= RUN;
                default: state <= RUN;
            endcase
            if (hif.PERF_CLR) begin
                cnt_dstall     <= '0;
                cnt_freeze_cyc <= '0;
                cnt_freeze_evt <= '0;
                cnt_flush      <= '0;
                streak         <= '0;
                hang           <= 1'b0;
            end else begin
                if (dstall && !freeze_req) cnt_dstall <= sat_inc(cnt_dstall);
                if (freeze_req) cnt_freeze_cyc <= sat_inc(cnt_freeze_cyc);
                if (state == RUN && freeze_req) cnt_freeze_evt <= sat_inc(cnt_freeze_evt);
                if (hif.IFID_Flush) cnt_flush <= sat_inc(cnt_flush);
                if (hif.PC_Write) begin
                    streak <= '0;
                end else begin
                    if (streak != STREAK_MAX) streak <= streak + 1'b1;
                    if (streak >= STREAK_LAST) hang <= 1'b1;
                end
            end
        end
    end

    assign hif.CNT_DSTALL     = cnt_dstall;
    assign hif.CNT_FREEZE_CYC = cnt_freeze_cyc;
    assign hif.CNT_FREEZE_EVT = cnt_freeze_evt;
    assign hif.CNT_FLUSH      = cnt_flush;
    assign hif.HANG           = hang;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit with directed vectors
module tb_hazard_control_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_control_if #(.CNT_W(4)) hif ();

    hazard_control_unit #(.CNT_W(4), .WDOG_LIMIT(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hif  (hif)
    );

    typedef struct packed {
        logic [6:0] ctl;
        logic [3:0] d;
        logic [3:0] c;
        logic [3:0] e;
        logic [3:0] f;
        logic       h;
    } exp_t;

    // ctl = {PC, IFID, IDEX, EXMEM, MEMWB writes, Bubble, Flush}
    localparam logic [6:0] ALLW = 7'b1111100;
    localparam logic [6:0] STL  = 7'b0011110;
    localparam logic [6:0] FRZ  = 7'b0000000;
    localparam logic [6:0] FLS  = 7'b1111101;

    exp_t  sb_q[$];
    string nm_q[$];
    int    nvec = 0;
    int    nmis = 0;

    task automatic push(input string nm, input logic [6:0] ctl, input logic [3:0] d,
                        input logic [3:0] c, input logic [3:0] e, input logic [3:0] f,
                        input logic h);
        exp_t x;
        x.ctl = ctl; x.d = d; x.c = c; x.e = e; x.f = f; x.h = h;
        sb_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic idle();
        hif.IFID_RS1 = 5'd0;      hif.IFID_RS2 = 5'd0;
        hif.IFID_USE_RS1 = 1'b0;  hif.IFID_USE_RS2 = 1'b0;
        hif.IFID_BRANCH = 1'b0;   hif.IDEX_RD = 5'd0;
        hif.IDEX_RegWrite = 1'b0; hif.IDEX_MemRead = 1'b0;
        hif.EXMEM_RD = 5'd0;      hif.EXMEM_MemRead = 1'b0;
        hif.BRANCH_TAKEN = 1'b0;  hif.ICACHE_STALL = 1'b0;
        hif.DCACHE_STALL = 1'b0;  hif.PERF_CLR = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  x;
            exp_t  a;
            string nm;
            x  = sb_q.pop_front();
            nm = nm_q.pop_front();
            a.ctl = {hif.PC_Write, hif.IFID_Write, hif.IDEX_Write, hif.EXMEM_Write,
                     hif.MEMWB_Write, hif.IDEX_Bubble, hif.IFID_Flush};
            a.d = hif.CNT_DSTALL;     a.c = hif.CNT_FREEZE_CYC;
            a.e = hif.CNT_FREEZE_EVT; a.f = hif.CNT_FLUSH;
            a.h = hif.HANG;
            nvec++;
            if (a !== x) begin
                nmis++;
                $display("FAIL %s: got ctl=%b dst=%0d fcyc=%0d fevt=%0d flush=%0d hang=%b, want ctl=%b dst=%0d fcyc=%0d fevt=%0d flush=%0d hang=%b",
                         nm, a.ctl, a.d, a.c, a.e, a.f, a.h, x.ctl, x.d, x.c, x.e, x.f, x.h);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", nvec);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        cyc(); push("reset_idle", ALLW, 0, 0, 0, 0, 0);
        cyc(); rst_n = 1'b1;

        // load-use: exactly one stall cycle
        cyc(); idle(); hif.IDEX_MemRead = 1; hif.IDEX_RegWrite = 1; hif.IDEX_RD = 5;
        hif.IFID_RS1 = 5; hif.IFID_USE_RS1 = 1;
        push("load_use", STL, 0, 0, 0, 0, 0);
        cyc(); idle(); hif.EXMEM_RD = 5; hif.EXMEM_MemRead = 1; hif.IFID_RS1 = 5; hif.IFID_USE_RS1 = 1;
        push("load_use_release", ALLW, 1, 0, 0, 0, 0);

        // x0 and unused sources
        cyc(); idle(); hif.IDEX_MemRead = 1; hif.IDEX_RD = 0; hif.IFID_RS1 = 0; hif.IFID_USE_RS1 = 1;
        push("x0_no_stall", ALLW, 1, 0, 0, 0, 0);
        cyc(); idle(); hif.IDEX_MemRead = 1; hif.IDEX_RD = 3; hif.IFID_RS2 = 3; hif.IFID_USE_RS2 = 0;
        hif.IFID_RS1 = 1; hif.IFID_USE_RS1 = 1;
        push("unused_rs2", ALLW, 1, 0, 0, 0, 0);

        // load feeding branch: BR_EX, BR_MEM, then taken
        cyc(); idle(); hif.IFID_BRANCH = 1; hif.IFID_RS2 = 7; hif.IFID_USE_RS2 = 1;
        hif.IDEX_RD = 7; hif.IDEX_RegWrite = 1; hif.IDEX_MemRead = 1;
        push("br_ex_load", STL, 1, 0, 0, 0, 0);
        cyc(); idle(); hif.IFID_BRANCH = 1; hif.IFID_RS2 = 7; hif.IFID_USE_RS2 = 1;
        hif.EXMEM_RD = 7; hif.EXMEM_MemRead = 1;
        push("br_mem_load", STL, 2, 0, 0, 0, 0);
        cyc(); idle(); hif.IFID_BRANCH = 1; hif.IFID_RS2 = 7; hif.IFID_USE_RS2 = 1; hif.BRANCH_TAKEN = 1;
        push("br_taken_flush", FLS, 3, 0, 0, 0, 0);
        cyc(); idle(); push("after_flush", ALLW, 3, 0, 0, 1, 0);

        // ALU result feeding branch: one stall, then EXMEM forwarding
        cyc(); idle(); hif.IFID_BRANCH = 1; hif.IFID_RS1 = 9; hif.IFID_USE_RS1 = 1;
        hif.IDEX_RD = 9; hif.IDEX_RegWrite = 1;
        push("br_ex_alu", STL, 3, 0, 0, 1, 0);
        cyc(); idle(); hif.IFID_BRANCH = 1; hif.IFID_RS1 = 9; hif.IFID_USE_RS1 = 1; hif.EXMEM_RD = 9;
        push("br_alu_fwd", ALLW, 4, 0, 0, 1, 0);

        // PERF_CLR, including clear winning over a same-cycle increment
        cyc(); idle(); hif.PERF_CLR = 1; push("clr_issue", ALLW, 4, 0, 0, 1, 0);
        cyc(); idle(); push("clr_done", ALLW, 0, 0, 0, 0, 0);
        cyc(); idle(); hif.PERF_CLR = 1; hif.IDEX_MemRead = 1; hif.IDEX_RD = 5;
        hif.IFID_RS1 = 5; hif.IFID_USE_RS1 = 1;
        push("clr_vs_stall", STL, 0, 0, 0, 0, 0);
        cyc(); idle(); push("clr_wins", ALLW, 0, 0, 0, 0, 0);

        // freeze beats load-use and taken branch for 4 cycles
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); hif.DCACHE_STALL = 1; hif.BRANCH_TAKEN = 1;
            hif.IDEX_MemRead = 1; hif.IDEX_RD = 5; hif.IFID_RS1 = 5; hif.IFID_USE_RS1 = 1;
            push("freeze_prio", FRZ, 0, 4'(i), (i > 0) ? 4'd1 : 4'd0, 0, 0);
        end
        cyc(); idle(); hif.BRANCH_TAKEN = 1;
        hif.IDEX_MemRead = 1; hif.IDEX_RD = 5; hif.IFID_RS1 = 5; hif.IFID_USE_RS1 = 1;
        push("post_freeze_stall", STL, 0, 4, 1, 0, 0);
        cyc(); idle(); push("post_freeze_idle", ALLW, 1, 4, 1, 0, 0);

        // miss dropping for one cycle counts as two events
        cyc(); idle(); hif.ICACHE_STALL = 1; push("evt_a", FRZ, 1, 4, 1, 0, 0);
        cyc(); idle(); push("evt_gap", ALLW, 1, 5, 2, 0, 0);
        cyc(); idle(); hif.ICACHE_STALL = 1; push("evt_b", FRZ, 1, 5, 2, 0, 0);
        cyc(); idle(); push("evt_count", ALLW, 1, 6, 3, 0, 0);

        // watchdog
        cyc(); idle(); hif.PERF_CLR = 1; push("wdog_clr", ALLW, 1, 6, 3, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(); idle(); hif.ICACHE_STALL = 1;
            push("wdog_hold", FRZ, 0, 4'(i), (i > 0) ? 4'd1 : 4'd0, 0, 0);
        end
        cyc(); idle(); push("wdog_hang_set", ALLW, 0, 8, 1, 0, 1);
        cyc(); idle(); push("wdog_hang_sticky", ALLW, 0, 8, 1, 0, 1);
        cyc(); idle(); hif.PERF_CLR = 1; push("wdog_clr_issue", ALLW, 0, 8, 1, 0, 1);
        cyc(); idle(); push("wdog_cleared", ALLW, 0, 0, 0, 0, 0);

        // flush counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(); idle(); hif.BRANCH_TAKEN = 1;
            push("sat_flush", FLS, 0, 0, 0, (i > 15) ? 4'd15 : 4'(i), 0);
        end
        cyc(); idle(); push("sat_hold", ALLW, 0, 0, 0, 15, 0);

        // reset mid-freeze
        cyc(); idle(); hif.DCACHE_STALL = 1; push("rst_frz_a", FRZ, 0, 0, 0, 15, 0);
        cyc(); idle(); hif.DCACHE_STALL = 1; push("rst_frz_b", FRZ, 0, 1, 1, 15, 0);
        cyc(); rst_n = 1'b0; push("rst_async_clear", FRZ, 0, 0, 0, 0, 0);
        cyc(); rst_n = 1'b1; push("rst_release", FRZ, 0, 0, 0, 0, 0);
        cyc(); push("rst_new_event", FRZ, 0, 1, 1, 0, 0);
        cyc(); idle(); push("rst_after", ALLW, 0, 2, 1, 0, 0);

        cyc();
        cyc();
        if (sb_q.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
